// File: rtl/riscv_pkg.sv
// Shared RV32 encodings and the M-extension engine state type.
// Imported by the EX-stage multiply/divide unit and its divider core.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage request/response bundle of the multiply/divide unit.
// master = pipeline side, slave = the unit.
interface ex_muldiv_unit_if;
  logic        start_in;
  logic [2:0]  funct3_in;
  logic [31:0] op_a_in;
  logic [31:0] op_b_in;
  logic [4:0]  rd_in;
  logic        flush_in;
  logic        stall_out;
  logic        done_out;
  logic [31:0] result_out;
  logic [4:0]  rd_out;

  modport master (
    output start_in, funct3_in, op_a_in,
    output op_b_in, rd_in, flush_in,
    input  stall_out, done_out,
    input  result_out, rd_out
  );

  modport slave (
    input  start_in, funct3_in, op_a_in,
    input  op_b_in, rd_in, flush_in,
    output stall_out, done_out,
    output result_out, rd_out
  );
endinterface

// File: rtl/muldiv_div_core.sv
// One step of an unsigned restoring divider: shift the partial
// remainder/dividend pair left, trial-subtract, emit one quotient bit.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  // MSB of the 33-bit difference is the borrow: set means restore
  assign rem_out = diff[XLEN] ? shifted[XLEN-1:0]
                              : diff[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_unit_if.slave bus
);

  muldiv_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic [4:0]       rd_q;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic             done_q;
  logic [XLEN-1:0]  res_q;
  logic [4:0]       rdo_q;

  logic [2:0]      f3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            is_div;
  logic            a_sgn;
  logic            b_sgn;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            ovf;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

  assign f3     = bus.funct3_in;
  assign a      = bus.op_a_in;
  assign b      = bus.op_b_in;
  assign is_div = f3[2];

  assign a_sgn = (f3 == F3_MUL) | (f3 == F3_MULH)
               | (f3 == F3_MULHSU) | (f3 == F3_DIV)
               | (f3 == F3_REM);
  assign b_sgn = (f3 == F3_MUL) | (f3 == F3_MULH)
               | (f3 == F3_DIV) | (f3 == F3_REM);

  assign neg_a = a_sgn & a[XLEN-1];
  assign neg_b = b_sgn & b[XLEN-1];
  assign abs_a = neg_a ? -a : a;
  assign abs_b = neg_b ? -b : b;

  assign ovf = ((f3 == F3_DIV) | (f3 == F3_REM))
             & (a == {1'b1, {(XLEN-1){1'b0}}})
             & (b == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa;
  logic [2*XLEN-1:0] fb;
  logic [2*XLEN-1:0] fprod;

  // Sign-extending to 64 bits gives the same low 64 bits as 33x33
  assign fa    = {{XLEN{a_sgn & a[XLEN-1]}}, a};
  assign fb    = {{XLEN{b_sgn & b[XLEN-1]}}, b};
  assign fprod = fa * fb;
`endif

  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    unique case (1'b1)
      is_div && (b == '0): begin
        fast_hit = 1'b1;
        fast_res = f3[1] ? a : '1;
      end
      ovf: begin
        fast_hit = 1'b1;
        fast_res = f3[1] ? '0
                         : {1'b1, {(XLEN-1){1'b0}}};
      end
`ifdef MULDIV_FAST_MUL_EN
      !is_div: begin
        fast_hit = 1'b1;
        fast_res = (f3 == F3_MUL) ? fprod[XLEN-1:0]
                                  : fprod[2*XLEN-1:XLEN];
      end
`endif
      default: ;
    endcase
  end

  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   mul_hi_n;
  logic [XLEN-1:0]   mul_lo_n;
  logic [XLEN-1:0]   div_rem_n;
  logic [XLEN-1:0]   div_quo_n;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   calc_res;

  // Shift-add: low half starts as the multiplier, drained LSB first
  assign sum      = {1'b0, hi}
                  + (lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi_n = sum[XLEN:1];
  assign mul_lo_n = {sum[0], lo[XLEN-1:1]};

  muldiv_div_core #(
    .XLEN(XLEN)
  ) u_div (
    .rem_in  (hi),
    .quo_in  (lo),
    .divisor (mcand),
    .rem_out (div_rem_n),
    .quo_out (div_quo_n)
  );

  assign prod_s = neg_q ? -{mul_hi_n, mul_lo_n}
                        : {mul_hi_n, mul_lo_n};
  assign quo_s  = neg_q ? -div_quo_n : div_quo_n;
  assign rem_s  = neg_r ? -div_rem_n : div_rem_n;

  always_comb begin
    calc_res = '0;
    unique case (op)
      F3_MUL:    calc_res = prod_s[XLEN-1:0];
      F3_MULH:   calc_res = prod_s[2*XLEN-1:XLEN];
      F3_MULHSU: calc_res = prod_s[2*XLEN-1:XLEN];
      F3_MULHU:  calc_res = prod_s[2*XLEN-1:XLEN];
      F3_DIV:    calc_res = quo_s;
      F3_DIVU:   calc_res = quo_s;
      F3_REM:    calc_res = rem_s;
      F3_REMU:   calc_res = rem_s;
      default:   calc_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
      res_q  <= '0;
      rdo_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush_in) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start_in) begin
              op    <= f3;
              rd_q  <= bus.rd_in;
              neg_q <= neg_a ^ neg_b;
              neg_r <= neg_a;
              cnt   <= '0;
              hi    <= '0;
              if (fast_hit) begin
                state  <= DONE;
                done_q <= 1'b1;
                res_q  <= fast_res;
                rdo_q  <= bus.rd_in;
              end else begin
                state <= CALC;
                mcand <= is_div ? abs_b : abs_a;
                lo    <= is_div ? abs_a : abs_b;
              end
            end
          end
          CALC: begin
            hi  <= op[2] ? div_rem_n : mul_hi_n;
            lo  <= op[2] ? div_quo_n : mul_lo_n;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) begin
              state  <= DONE;
              cnt    <= '0;
              done_q <= 1'b1;
              res_q  <= calc_res;
              rdo_q  <= rd_q;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.stall_out  = ~rst
    & (((state == IDLE) & bus.start_in & ~bus.flush_in)
       | (state == CALC));
  assign bus.done_out   = done_q;
  assign bus.result_out = res_q;
  assign bus.rd_out     = rdo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: fast paths, iterative
// mul/div, flush and synchronous reset behaviour.
module tb_ex_muldiv_unit;
  import riscv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp,
                        input int lat);
    int   n;
    logic seen;
    logic stall_ok;
    bus.start_in  = 1'b1;
    bus.funct3_in = f3;
    bus.op_a_in   = a;
    bus.op_b_in   = b;
    bus.rd_in     = rd;
    #1;
    stall_ok = bus.stall_out;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.done_out) seen = 1'b1;
      else if (!bus.stall_out) stall_ok = 1'b0;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_res"}, bus.result_out, exp);
    chk({tag, "_rd"}, 32'(bus.rd_out), 32'(rd));
    chk({tag, "_stall"}, 32'(stall_ok), 32'd1);
    chk({tag, "_stall_done"}, 32'(bus.stall_out), 32'd0);
    bus.start_in = 1'b0;
    tick();
  endtask

  initial begin
    int dcnt;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start_in  = 1'b0;
    bus.funct3_in = '0;
    bus.op_a_in   = '0;
    bus.op_b_in   = '0;
    bus.rd_in     = '0;
    bus.flush_in  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.stall_out), 32'd0);
    chk("rst_done", 32'(bus.done_out), 32'd0);
    chk("rst_res", bus.result_out, 32'd0);
    chk("rst_rd", 32'(bus.rd_out), 32'd0);

    run_op("mul", F3_MUL, 32'd7, 32'hFFFFFFFD,
           5'd1, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulh", F3_MULH, 32'h80000000, 32'h80000000,
           5'd2, 32'h40000000, MUL_LAT);
    run_op("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           5'd3, 32'hFFFFFFFF, MUL_LAT);
    run_op("mulhu", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           5'd4, 32'hFFFFFFFE, MUL_LAT);
    run_op("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF,
           5'd5, 32'h80000000, 1);
    run_op("rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF,
           5'd6, 32'h00000000, 1);
    run_op("divu_z", F3_DIVU, 32'd5, 32'd0,
           5'd7, 32'hFFFFFFFF, 1);
    run_op("remu_z", F3_REMU, 32'd5, 32'd0,
           5'd8, 32'd5, 1);
    run_op("rem_z", F3_REM, 32'hFFFFFFF9, 32'd0,
           5'd9, 32'hFFFFFFF9, 1);
    run_op("rem_neg", F3_REM, 32'hFFFFFFF9, 32'd2,
           5'd10, 32'hFFFFFFFF, 33);
    run_op("div_neg", F3_DIV, 32'hFFFFFFF9, 32'd2,
           5'd11, 32'hFFFFFFFD, 33);
    run_op("divu", F3_DIVU, 32'd100, 32'd7,
           5'd12, 32'd14, 33);
    run_op("remu", F3_REMU, 32'hFFFFFFFF, 32'd10,
           5'd13, 32'd5, 33);

    // flush in the middle of a signed divide
    bus.start_in  = 1'b1;
    bus.funct3_in = F3_DIV;
    bus.op_a_in   = 32'hFFFFFFF9;
    bus.op_b_in   = 32'd2;
    bus.rd_in     = 5'd3;
    dcnt = 0;
    repeat (10) begin
      tick();
      if (bus.done_out) dcnt++;
    end
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    bus.start_in = 1'b0;
    #1;
    if (bus.done_out) dcnt++;
    chk("flush_done", 32'(dcnt), 32'd0);
    chk("flush_stall", 32'(bus.stall_out), 32'd0);
    run_op("after_flush", F3_DIVU, 32'd100, 32'd7,
           5'd9, 32'd14, 33);

    // synchronous reset mid-divide
    bus.start_in  = 1'b1;
    bus.funct3_in = F3_DIVU;
    bus.op_a_in   = 32'd1000;
    bus.op_b_in   = 32'd3;
    bus.rd_in     = 5'd5;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    bus.start_in = 1'b0;
    #1;
    chk("midrst_stall", 32'(bus.stall_out), 32'd0);
    chk("midrst_done", 32'(bus.done_out), 32'd0);
    chk("midrst_res", bus.result_out, 32'd0);
    chk("midrst_rd", 32'(bus.rd_out), 32'd0);

    rst          = 1'b1;
    bus.start_in = 1'b1;
    repeat (2) tick();
    rst          = 1'b0;
    bus.start_in = 1'b0;
    dcnt = 0;
    repeat (40) begin
      tick();
      if (bus.done_out || bus.stall_out) dcnt++;
    end
    chk("rst_start_ign", 32'(dcnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
